// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch (IF) and data access (ME).
// ME wins conflicts unless IF has already been denied MAXWAIT consecutive cycles.
module mem_port_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 32,
    parameter int MAXWAIT = 3,
    parameter int CW      = 16
) (
    input  logic          w_clk,
    input  logic          w_rst,
    input  logic          w_if_req,
    input  logic [AW-1:0] w_if_addr,
    input  logic          w_if_flush,
    output logic          w_if_gnt,
    output logic [DW-1:0] w_if_rdata,
    output logic          r_if_rvalid,
    input  logic          w_me_req,
    input  logic          w_me_we,
    input  logic [AW-1:0] w_me_addr,
    input  logic [DW-1:0] w_me_din,
    output logic          w_me_gnt,
    output logic [DW-1:0] w_me_rdata,
    output logic          r_me_rvalid,
    output logic [AW-1:0] w_mem_addr,
    output logic          w_mem_we,
    output logic [DW-1:0] w_mem_din,
    input  logic [DW-1:0] w_mem_dout,
    output logic [CW-1:0] r_conflicts
);

    // A one-bit counter is still kept when MAXWAIT is 0; it simply never leaves zero.
    localparam int SW = (MAXWAIT > 0) ? $clog2(MAXWAIT + 1) : 1;
    localparam logic [SW-1:0] MAXW = SW'(MAXWAIT);

    typedef enum logic [1:0] {
        S_NONE = 2'd0,
        S_IF   = 2'd1,
        S_ME   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [AW-1:0] addr_q;
    logic          if_wins;

    always_comb begin
        if_wins  = (starve_q == MAXW);
        w_if_gnt = w_rst & w_if_req & (~w_me_req | if_wins);
        w_me_gnt = w_rst & w_me_req & ~(w_if_req & if_wins);

        w_mem_addr = addr_q;
        w_mem_we   = 1'b0;
        w_mem_din  = w_me_din;
        if (w_me_gnt) begin
            w_mem_addr = w_me_addr;
            w_mem_we   = w_me_we;
        end else if (w_if_gnt) begin
            w_mem_addr = w_if_addr;
        end

        // A flushed IF read still hits the RAM; only its data return is dropped.
        state_d = S_NONE;
        if (w_if_gnt && !w_if_flush) begin
            state_d = S_IF;
        end else if (w_me_gnt && !w_me_we) begin
            state_d = S_ME;
        end

        starve_d = '0;
        if (w_if_req && !w_if_gnt) begin
            starve_d = (starve_q == MAXW) ? starve_q : starve_q + 1'b1;
        end
    end

    assign w_if_rdata = w_mem_dout;
    assign w_me_rdata = w_mem_dout;

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            state_q     <= S_NONE;
            r_if_rvalid <= 1'b0;
            r_me_rvalid <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_if_rvalid <= (state_d == S_IF);
            r_me_rvalid <= (state_d == S_ME);
        end
    end

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            starve_q    <= '0;
            addr_q      <= '0;
            r_conflicts <= '0;
        end else begin
            starve_q <= starve_d;
            addr_q   <= w_mem_addr;
            if (w_if_req && w_me_req && !(&r_conflicts)) begin
                r_conflicts <= r_conflicts + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a reference arbiter and memory model predict grants,
// memory drive and returned read data; a second instance covers MAXWAIT=0 and counter saturation.
module tb_mem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          if_req = 1'b0, if_flush = 1'b0, me_req = 1'b0, me_we = 1'b0;
    logic [AW-1:0] if_addr = '0, me_addr = '0;
    logic [DW-1:0] me_din = '0;
    logic          if_gnt, me_gnt, if_rvalid, me_rvalid, mem_we;
    logic [DW-1:0] if_rdata, me_rdata, mem_din, mem_dout;
    logic [AW-1:0] mem_addr;
    logic [15:0]   conflicts;

    logic          b_if_req = 1'b0, b_me_req = 1'b0;
    logic          b_if_gnt, b_me_gnt, b_if_rvalid, b_me_rvalid, b_mem_we;
    logic [DW-1:0] b_if_rdata, b_me_rdata, b_mem_din;
    logic [DW-1:0] b_mem_dout = '0;
    logic [AW-1:0] b_mem_addr;
    logic [3:0]    b_conflicts;

    logic [DW-1:0] ram [0:4095];
    logic [DW-1:0] ref_mem [0:4095];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(MW), .CW(16)) dut (
        .w_clk(clk), .w_rst(rst_n),
        .w_if_req(if_req), .w_if_addr(if_addr), .w_if_flush(if_flush),
        .w_if_gnt(if_gnt), .w_if_rdata(if_rdata), .r_if_rvalid(if_rvalid),
        .w_me_req(me_req), .w_me_we(me_we), .w_me_addr(me_addr), .w_me_din(me_din),
        .w_me_gnt(me_gnt), .w_me_rdata(me_rdata), .r_me_rvalid(me_rvalid),
        .w_mem_addr(mem_addr), .w_mem_we(mem_we), .w_mem_din(mem_din),
        .w_mem_dout(mem_dout), .r_conflicts(conflicts)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(0), .CW(4)) dut_b (
        .w_clk(clk), .w_rst(rst_n),
        .w_if_req(b_if_req), .w_if_addr(12'h005), .w_if_flush(1'b0),
        .w_if_gnt(b_if_gnt), .w_if_rdata(b_if_rdata), .r_if_rvalid(b_if_rvalid),
        .w_me_req(b_me_req), .w_me_we(1'b0), .w_me_addr(12'h009), .w_me_din(32'h0),
        .w_me_gnt(b_me_gnt), .w_me_rdata(b_me_rdata), .r_me_rvalid(b_me_rvalid),
        .w_mem_addr(b_mem_addr), .w_mem_we(b_mem_we), .w_mem_din(b_mem_din),
        .w_mem_dout(b_mem_dout), .r_conflicts(b_conflicts)
    );

    // Single-port RAM, registered read, read-before-write.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic fl,
                         input logic mr, input logic mw, input logic [AW-1:0] ma,
                         input logic [DW-1:0] md);
        @(posedge clk);
        #1;
        if_req = ir; if_addr = ia; if_flush = fl;
        me_req = mr; me_we = mw; me_addr = ma; me_din = md;
    endtask

    // Reference model and scoreboard, evaluated mid-cycle.
    logic [DW-1:0] q_if[$];
    logic [DW-1:0] q_me[$];
    logic [1:0]    m_starve = '0;
    logic          m_pend_if = 1'b0, m_pend_me = 1'b0;
    logic [15:0]   m_conf = '0;
    logic [AW-1:0] m_addr = '0;
    logic          cont_ph = 1'b0;
    int            cont_if_gnts = 0;

    always @(negedge clk) begin
        logic          e_if, e_me;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        if (!rst_n) begin
            check_eq("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
            check_eq("rst_me_gnt", {31'b0, me_gnt}, 32'd0);
            check_eq("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
            check_eq("rst_me_rvalid", {31'b0, me_rvalid}, 32'd0);
            check_eq("rst_conflicts", {16'b0, conflicts}, 32'd0);
            check_eq("rst_mem_we", {31'b0, mem_we}, 32'd0);
            m_starve = '0; m_pend_if = 1'b0; m_pend_me = 1'b0;
            m_conf = '0; m_addr = '0;
            q_if.delete(); q_me.delete();
        end else begin
            check_eq("if_rvalid", {31'b0, if_rvalid}, {31'b0, m_pend_if});
            check_eq("me_rvalid", {31'b0, me_rvalid}, {31'b0, m_pend_me});
            if (m_pend_if && q_if.size() > 0) begin
                e_data = q_if.pop_front();
                check_eq("if_rdata", if_rdata, e_data);
            end
            if (m_pend_me && q_me.size() > 0) begin
                e_data = q_me.pop_front();
                check_eq("me_rdata", me_rdata, e_data);
            end
            check_eq("conflicts", {16'b0, conflicts}, {16'b0, m_conf});

            e_if = if_req && (!me_req || m_starve == 2'(MW));
            e_me = me_req && !e_if;
            check_eq("if_gnt", {31'b0, if_gnt}, {31'b0, e_if});
            check_eq("me_gnt", {31'b0, me_gnt}, {31'b0, e_me});
            check_eq("mem_we", {31'b0, mem_we}, {31'b0, e_me && me_we});
            e_addr = e_me ? me_addr : (e_if ? if_addr : m_addr);
            check_eq("mem_addr", {20'b0, mem_addr}, {20'b0, e_addr});
            if (e_me && me_we) check_eq("mem_din", mem_din, me_din);
            if (cont_ph && if_gnt) cont_if_gnts++;

            m_pend_if = e_if && !if_flush;
            m_pend_me = e_me && !me_we;
            if (m_pend_if) q_if.push_back(ref_mem[if_addr]);
            if (m_pend_me) q_me.push_back(ref_mem[me_addr]);
            if (e_me && me_we) ref_mem[me_addr] = me_din;
            m_addr = e_addr;
            m_starve = (if_req && !e_if) ? ((m_starve == 2'(MW)) ? m_starve : m_starve + 2'd1) : 2'd0;
            if (if_req && me_req && m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
        end
    end

    // MAXWAIT=0 instance: IF always wins and the 4-bit conflict counter saturates.
    logic ph_b = 1'b0;
    logic [3:0] b_exp_conf = '0;
    always @(negedge clk) begin
        if (ph_b && rst_n) begin
            check_eq("b_if_gnt", {31'b0, b_if_gnt}, 32'd1);
            check_eq("b_me_gnt", {31'b0, b_me_gnt}, 32'd0);
            check_eq("b_conflicts", {28'b0, b_conflicts}, {28'b0, b_exp_conf});
            if (b_exp_conf != 4'hF) b_exp_conf = b_exp_conf + 4'd1;
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 32'h1000_0000 + i * 7;
            ref_mem[i] = 32'h1000_0000 + i * 7;
        end
        mem_dout = '0;
        #2 rst_n = 1'b0;

        drive(1, 12'd4, 0, 1, 0, 12'd6, 0);
        drive(1, 12'd4, 0, 1, 0, 12'd6, 0);

        // IF-only reads of 0,1,2 right out of reset
        drive(1, 12'd0, 0, 0, 0, 12'd0, 0); rst_n = 1'b1;
        drive(1, 12'd1, 0, 0, 0, 12'd0, 0);
        drive(1, 12'd2, 0, 0, 0, 12'd0, 0);
        drive(0, 12'd0, 0, 0, 0, 12'd0, 0);
        drive(0, 12'd0, 0, 0, 0, 12'd0, 0);
        check_eq("conflicts_after_if_only", {16'b0, conflicts}, 32'd0);

        // Store then load same address
        drive(0, 12'd0, 0, 1, 1, 12'd0, 32'h20);
        drive(0, 12'd0, 0, 1, 0, 12'd0, 0);
        drive(0, 12'd0, 0, 0, 0, 12'd0, 0);
        drive(0, 12'd0, 0, 0, 0, 12'd0, 0);

        // Continuous contention: ME,ME,ME,IF repeating
        cont_ph = 1'b1;
        for (int i = 0; i < 12; i++) drive(1, 12'd5, 0, 1, 0, 12'(10 + i), 0);
        drive(0, 12'd0, 0, 0, 0, 12'd0, 0);
        cont_ph = 1'b0;
        check_eq("cont_if_grants", cont_if_gnts, 32'd3);
        check_eq("cont_conflicts", {16'b0, conflicts}, 32'd12);

        // Flushed IF read, flush without IF grant, then a normal IF read
        drive(1, 12'd7, 1, 0, 0, 12'd0, 0);
        drive(0, 12'd0, 1, 1, 0, 12'd9, 0);
        drive(1, 12'd8, 0, 0, 0, 12'd0, 0);
        drive(0, 12'd0, 0, 0, 0, 12'd0, 0);

        // Read followed by write to the same address, back to back
        drive(0, 12'd0, 0, 1, 0, 12'd3, 0);
        drive(0, 12'd0, 0, 1, 1, 12'd3, 32'hABCD);
        drive(0, 12'd0, 0, 1, 0, 12'd3, 0);
        drive(1, 12'd4, 0, 0, 0, 12'd0, 0);
        drive(0, 12'd0, 0, 1, 1, 12'd4, 32'h5555);
        drive(1, 12'd4, 0, 0, 0, 12'd0, 0);
        drive(0, 12'd0, 0, 0, 0, 12'd0, 0);

        // Random mix on a small address window
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  12'($urandom_range(0, 15)), $urandom);
        end
        drive(0, 12'd0, 0, 0, 0, 12'd0, 0);
        drive(0, 12'd0, 0, 0, 0, 12'd0, 0);

        // Reset in the cycle after an ME load grant drops its data return
        drive(0, 12'd0, 0, 1, 0, 12'd1, 0);
        drive(1, 12'd2, 0, 1, 0, 12'd3, 0); rst_n = 1'b0;
        drive(1, 12'd2, 0, 1, 0, 12'd3, 0);
        drive(1, 12'd2, 0, 0, 0, 12'd0, 0); rst_n = 1'b1;
        drive(0, 12'd0, 0, 0, 0, 12'd0, 0);
        drive(0, 12'd0, 0, 0, 0, 12'd0, 0);

        // MAXWAIT=0 instance under continuous contention
        @(posedge clk); #1;
        b_if_req = 1'b1; b_me_req = 1'b1; ph_b = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        b_if_req = 1'b0; b_me_req = 1'b0; ph_b = 1'b0;
        @(negedge clk);
        check_eq("b_conflicts_sat", {28'b0, b_conflicts}, 32'hF);

        @(negedge clk);
        check_eq("q_if_drained", q_if.size(), 32'd0);
        check_eq("q_me_drained", q_me.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM (4096 x 32, registered read data, one-cycle read latency, write on clock edge when we=1) between the instruction-fetch requester (IF) and the data-access requester (ME) of the 5-stage pipeline.
- Grants at most one access per cycle and routes the returned read data to the owning requester with a valid pulse.
- Guarantees IF forward progress with a starvation bound.
- Sits between the processor pipeline and a unified instruction/data memory instance.

Parameters:
- AW, 12, word-address width to memory.
- DW, 32, data width.
- MAXWAIT, 3, max consecutive cycles IF may be denied while requesting; 0 gives IF absolute priority.
- CW, 16, width of the conflict statistics counter.

Ports:
- w_clk  in  1  clock, all state on rising edge
- w_rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- w_if_req  in  1  IF read request; held with address until granted
- w_if_addr  in  AW  IF word address
- w_if_flush  in  1  cancel the IF access granted in this same cycle
- w_if_gnt  out  1  IF granted this cycle (combinational)
- w_if_rdata  out  DW  IF read data, valid when r_if_rvalid=1
- r_if_rvalid  out  1  IF read-data valid, registered
- w_me_req  in  1  ME request
- w_me_we  in  1  ME write enable (1 = store, 0 = load)
- w_me_addr  in  AW  ME word address
- w_me_din  in  DW  ME store data
- w_me_gnt  out  1  ME granted this cycle (combinational)
- w_me_rdata  out  DW  ME load data, valid when r_me_rvalid=1
- r_me_rvalid  out  1  ME load-data valid, registered
- w_mem_addr  out  AW  to RAM address
- w_mem_we  out  1  to RAM write enable
- w_mem_din  out  DW  to RAM write data
- w_mem_dout  in  DW  from RAM registered read data
- r_conflicts  out  CW  saturating count of cycles with both requests active

Behaviour:
- Grant decision (combinational, per cycle):
  - Both gnts are 0 while w_rst=0.
  - Only one requester active: that requester is granted.
  - Both active: ME wins unless r_starve == MAXWAIT, in which case IF wins.
  - w_if_gnt and w_me_gnt are never both 1.
- Memory drive:
  - ME granted: addr = w_me_addr, we = w_me_we, din = w_me_din.
  - IF granted: addr = w_if_addr, we = 0.
  - No grant: addr holds the last driven value, we = 0.
  - w_mem_we = 1 only with w_me_gnt & w_me_we.
- Owner state (registered) takes one of three values: S_NONE, S_IF, S_ME.
  - Next state is S_IF if the IF grant is not flushed; S_ME if ME is granted with we=0; otherwise S_NONE.
  - r_if_rvalid = (state==S_IF); r_me_rvalid = (state==S_ME).
  - Each rvalid is a one-cycle pulse, one cycle after its grant.
- w_if_rdata and w_me_rdata both equal w_mem_dout; consumers qualify with rvalid.
- Stores produce no rvalid.
- Back-to-back grants are allowed every cycle, including a read followed by a write to the same address. The read returns the old data, per RAM read-before-write.
- Starvation counter r_starve (internal, width clog2(MAXWAIT+1)):
  - Increments when w_if_req=1 and w_if_gnt=0.
  - Clears when IF is granted or w_if_req=0.
  - Never exceeds MAXWAIT.
- Flush:
  - w_if_flush=1 in the grant cycle suppresses the next r_if_rvalid.
  - The RAM read still occurs and the grant still counts as service, so r_starve clears.
  - Flush with no IF grant has no effect.
- r_conflicts increments when w_if_req & w_me_req, saturating at all ones.
- Reset: w_rst=0 asynchronously clears state to S_NONE, both rvalids to 0, r_starve to 0, r_conflicts to 0, and the held address to 0.
  - Any in-flight read is dropped with no rvalid.
  - The first grant is possible in the first cycle after w_rst returns to 1.
- Requests that drop before being granted are legal; no state is retained for them except r_starve clearing.

Test Plan:
- Reset then IF-only reads of addr 0,1,2 on consecutive cycles -> w_if_gnt=1 each cycle; r_if_rvalid high for 3 cycles, starting one cycle after the first grant; rdata = RAM[0..2]; r_conflicts=0.
- ME store 0x20 to addr 0, next cycle ME load addr 0 -> store produces no rvalid; load gives r_me_rvalid=1 with rdata=0x20 one cycle later.
- Both requesting continuously with MAXWAIT=3 -> grant pattern ME,ME,ME,IF repeating; r_conflicts increments every cycle and saturates at 0xFFFF.
- MAXWAIT=0 with both requesting -> IF granted every cycle; ME never granted while IF requests.
- IF granted with w_if_flush=1 -> no r_if_rvalid the next cycle; a following unflushed IF grant returns data normally.
- Assert w_rst=0 in the cycle after an ME load grant -> r_me_rvalid stays 0; r_conflicts=0; both gnts=0 during reset.
